nibble_serial_adder: RTL and testbench
======================================

Name: nibble_serial_adder

Overview:
Nibble-serial 32-bit adder controller. It adds two 32-bit operands one 4-bit slice per cycle, least significant slice first, using a registered ripple carry. Its 3-bit slice index drives the downstream 3-to-8 decoder, which produces the one-hot slice enables for the datapath. Valid/ready handshakes sit on both the operand side and the result side.

Parameters:
WIDTH, 32, operand and sum width; must equal SLICE_W*8.
SLICE_W, 4, bits added per cycle (one slice).

Ports:
clk  input  1  single clock; all state updates on the rising edge.
rst  input  1  asynchronous, active-high reset.
in_valid  input  1  operand word valid.
in_ready  output  1  block can accept operands.
a  input  WIDTH  operand A.
b  input  WIDTH  operand B.
cin  input  1  carry-in for slice 0.
slice_sel  output  3  index of the slice being added; feeds the 3-to-8 decoder.
slice_act  output  1  slice_sel is meaningful this cycle (RUN state).
busy  output  1  high in RUN or DONE.
out_valid  output  1  sum/cout valid.
out_ready  input  1  consumer accepts the result.
sum  output  WIDTH  registered result.
cout  output  1  carry-out of slice 7.

Behaviour:
- Reset (asynchronous, takes effect immediately):
  - state=IDLE, idx=0, carry=0, a_reg=b_reg=0, sum=0, cout=0.
  - in_ready=1, out_valid=0, busy=0, slice_act=0, slice_sel=0.
- FSM states: IDLE, RUN, DONE. All outputs are decoded from registers; no input-to-output combinational path.
- IDLE:
  - in_ready=1.
  - On in_valid&in_ready at an edge: a_reg<=a, b_reg<=b, carry<=cin, idx<=0, sum<=0, state<=RUN.
- RUN:
  - in_ready=0, slice_act=1, slice_sel=idx.
  - Each edge computes t = a_reg[idx*4+:4] + b_reg[idx*4+:4] + carry as a 5-bit value.
  - sum[idx*4+:4]<=t[3:0]; carry<=t[4].
  - If idx==7: cout<=t[4], state<=DONE, idx<=0. Otherwise idx<=idx+1.
- Latency:
  - Accept edge at cycle T; RUN occupies cycles T+1..T+8 with slice_sel=0..7 in order.
  - out_valid=1 from cycle T+9. Exactly 8 RUN cycles always; there is no early termination on zero carry.
- DONE:
  - out_valid=1; sum and cout held stable.
  - On out_ready at an edge: state<=IDLE. out_valid falls and in_ready rises the following cycle.
  - Holds indefinitely while out_ready=0.
- Handshake:
  - in_ready is low outside IDLE, so operands cannot be accepted while a result is pending. No bypass.
  - Operand-side inputs are ignored outside IDLE.
  - out_ready is ignored outside DONE.
- Arithmetic:
  - Unsigned modulo 2^32; cout is the true carry-out.
  - sum = (a+b+cin) mod 2^32; cout = (a+b+cin) >> 32.
- sum during RUN: partially updated; not valid until out_valid=1.
- Reset mid-RUN or mid-DONE: returns to the reset values above; any pending result is lost; no out_valid pulse.
- idx wrap: idx never exceeds 7. The 7-to-0 transition occurs only on the RUN->DONE edge.

Test Plan:
1. Reset, then a=0x12345678, b=0x11111111, cin=0, out_ready=1 -> slice_sel steps 0..7 over 8 cycles with slice_act=1; out_valid at T+9; sum=0x23456789, cout=0.
2. a=0xFFFFFFFF, b=0x00000001, cin=0 -> carry ripples through all 8 slices; sum=0x00000000, cout=1.
3. a=0, b=0, cin=1 -> sum=0x00000001, cout=0. Then a=0xFFFFFFFF, b=0xFFFFFFFF, cin=1 -> sum=0xFFFFFFFF, cout=1.
4. Backpressure: out_ready=0 for 5 cycles after out_valid -> out_valid, sum and cout stay stable; in_ready=0 throughout; in_valid with new operands is ignored. Raise out_ready -> IDLE next cycle; next operation uses the new operands only after in_ready=1.
5. Assert rst at the 4th RUN cycle (slice_sel=3) -> all outputs immediately return to reset values (sum=0, in_ready=1). A subsequent a=0x0000000F, b=0x00000001 -> sum=0x00000010, cout=0.
6. Back-to-back: in_valid held high with out_ready=1 -> a new accept every 10 cycles (1 IDLE + 8 RUN + 1 DONE); sums correct for 0x80000000+0x80000000 (sum=0, cout=1) followed by 0x7FFFFFFF+0x00000001 (sum=0x80000000, cout=0).

Source files
------------

// File: rtl/nibble_serial_adder.sv
// Nibble-serial adder: adds two WIDTH-bit operands one SLICE_W-bit slice per cycle,
// LSB slice first, with a registered ripple carry and valid/ready on both sides.
module nibble_serial_adder #(
    parameter int WIDTH   = 32,
    parameter int SLICE_W = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    output logic [2:0]       slice_sel,
    output logic             slice_act,
    output logic             busy,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] sum,
    output logic             cout
);
    // WIDTH must equal SLICE_W*8 so that a 3-bit slice index covers the whole word.
    localparam int IW = $clog2(WIDTH);

    typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_t;

    state_t             r_state;
    state_t             w_next;
    logic [2:0]         r_idx;
    logic               r_carry;
    logic [WIDTH-1:0]   r_a;
    logic [WIDTH-1:0]   r_b;
    logic [WIDTH-1:0]   r_sum;
    logic               r_cout;

    logic [IW-1:0]      w_base;
    logic [SLICE_W-1:0] w_a_sl;
    logic [SLICE_W-1:0] w_b_sl;
    logic [SLICE_W:0]   w_t;

    assign w_base = IW'(r_idx) * IW'(SLICE_W);
    assign w_a_sl = r_a[w_base +: SLICE_W];
    assign w_b_sl = r_b[w_base +: SLICE_W];
    assign w_t    = {1'b0, w_a_sl} + {1'b0, w_b_sl} + (SLICE_W+1)'(r_carry);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) r_state <= S_IDLE;
        else     r_state <= w_next;
    end

    always_comb begin
        w_next    = r_state;
        in_ready  = 1'b0;
        slice_act = 1'b0;
        slice_sel = 3'd0;
        busy      = 1'b0;
        out_valid = 1'b0;
        case (r_state)
            S_IDLE: begin
                in_ready = 1'b1;
                if (in_valid) w_next = S_RUN;
            end
            S_RUN: begin
                slice_act = 1'b1;
                slice_sel = r_idx;
                busy      = 1'b1;
                if (r_idx == 3'd7) w_next = S_DONE;
            end
            S_DONE: begin
                busy      = 1'b1;
                out_valid = 1'b1;
                if (out_ready) w_next = S_IDLE;
            end
            default: w_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_idx   <= 3'd0;
            r_carry <= 1'b0;
            r_a     <= '0;
            r_b     <= '0;
            r_sum   <= '0;
            r_cout  <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (in_valid) begin
                        r_a     <= a;
                        r_b     <= b;
                        r_carry <= cin;
                        r_idx   <= 3'd0;
                        r_sum   <= '0;
                    end
                end
                S_RUN: begin
                    r_sum[w_base +: SLICE_W] <= w_t[SLICE_W-1:0];
                    r_carry                  <= w_t[SLICE_W];
                    if (r_idx == 3'd7) begin
                        r_cout <= w_t[SLICE_W];
                        r_idx  <= 3'd0;
                    end else begin
                        r_idx  <= r_idx + 3'd1;
                    end
                end
                default: ;
            endcase
        end
    end

    assign sum  = r_sum;
    assign cout = r_cout;

endmodule

// File: tb/tb_nibble_serial_adder.sv
// Self-checking bench for nibble_serial_adder: directed vector table, backpressure,
// mid-run reset, back-to-back throughput and random operands vs a 33-bit add model.
module tb_nibble_serial_adder;
    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] a, b;
    logic        cin;
    logic [2:0]  slice_sel;
    logic        slice_act;
    logic        busy;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] sum;
    logic        cout;

    int errors = 0;
    int checks = 0;

    nibble_serial_adder #(.WIDTH(32), .SLICE_W(4)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
        .a(a), .b(b), .cin(cin), .slice_sel(slice_sel), .slice_act(slice_act),
        .busy(busy), .out_valid(out_valid), .out_ready(out_ready),
        .sum(sum), .cout(cout)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] a;
        logic [31:0] b;
        logic        cin;
        logic [31:0] exp_sum;
        logic        exp_cout;
    } vec_t;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic chk_reset_outs(input string tag);
        chk({tag, ".in_ready"},  64'(in_ready),  64'd1);
        chk({tag, ".out_valid"}, 64'(out_valid), 64'd0);
        chk({tag, ".busy"},      64'(busy),      64'd0);
        chk({tag, ".slice_act"}, 64'(slice_act), 64'd0);
        chk({tag, ".slice_sel"}, 64'(slice_sel), 64'd0);
        chk({tag, ".sum"},       64'(sum),       64'd0);
        chk({tag, ".cout"},      64'(cout),      64'd0);
    endtask

    // Waits (bounded) for IDLE, issues one operation, checks the slice walk and
    // the result; holds out_ready low for 'hold' cycles of DONE before releasing.
    task automatic run_op(input logic [31:0] ta, input logic [31:0] tb_,
                          input logic tcin, input logic [31:0] es, input logic ec,
                          input int hold, input string tag);
        int w;
        w = 0;
        while (!in_ready && w < 30) begin @(negedge clk); w++; end
        if (!in_ready) chk({tag, ".wait_in_ready"}, 64'(in_ready), 64'd1);
        out_ready = (hold == 0);
        in_valid = 1'b1; a = ta; b = tb_; cin = tcin;
        @(negedge clk);
        in_valid = 1'b0; a = ~ta; b = ~tb_; cin = ~tcin;
        for (int k = 0; k < 8; k++) begin
            chk($sformatf("%s.slice_act[%0d]", tag, k), 64'(slice_act), 64'd1);
            chk($sformatf("%s.slice_sel[%0d]", tag, k), 64'(slice_sel), 64'(k));
            if (k == 0 || k == 7) begin
                chk($sformatf("%s.in_ready_run[%0d]", tag, k), 64'(in_ready), 64'd0);
                chk($sformatf("%s.out_valid_run[%0d]", tag, k), 64'(out_valid), 64'd0);
            end
            @(negedge clk);
        end
        chk({tag, ".out_valid"}, 64'(out_valid), 64'd1);
        chk({tag, ".sum"},       64'(sum),       64'(es));
        chk({tag, ".cout"},      64'(cout),      64'(ec));
        for (int h = 0; h < hold; h++) begin
            in_valid = 1'b1; a = 32'hDEAD0000 + 32'(h); b = 32'h1; cin = 1'b0;
            @(negedge clk);
            chk($sformatf("%s.hold_valid[%0d]", tag, h), 64'(out_valid), 64'd1);
            chk($sformatf("%s.hold_sum[%0d]", tag, h),   64'(sum),       64'(es));
            chk($sformatf("%s.hold_cout[%0d]", tag, h),  64'(cout),      64'(ec));
            chk($sformatf("%s.hold_inrdy[%0d]", tag, h), 64'(in_ready),  64'd0);
        end
        in_valid = 1'b0;
        out_ready = 1'b1;
        @(negedge clk);
        chk({tag, ".post_out_valid"}, 64'(out_valid), 64'd0);
        chk({tag, ".post_in_ready"},  64'(in_ready),  64'd1);
    endtask

    vec_t vecs[6];
    logic [32:0] model;
    logic [31:0] ra, rb;
    logic        rc;

    initial begin
        vecs[0] = '{32'h12345678, 32'h11111111, 1'b0, 32'h23456789, 1'b0};
        vecs[1] = '{32'hFFFFFFFF, 32'h00000001, 1'b0, 32'h00000000, 1'b1};
        vecs[2] = '{32'h00000000, 32'h00000000, 1'b1, 32'h00000001, 1'b0};
        vecs[3] = '{32'hFFFFFFFF, 32'hFFFFFFFF, 1'b1, 32'hFFFFFFFF, 1'b1};
        vecs[4] = '{32'h80000000, 32'h80000000, 1'b0, 32'h00000000, 1'b1};
        vecs[5] = '{32'h0F0F0F0F, 32'hF0F0F0F0, 1'b1, 32'h00000000, 1'b1};

        rst = 1'b1; in_valid = 1'b0; a = '0; b = '0; cin = 1'b0; out_ready = 1'b1;
        #1;
        chk_reset_outs("reset");
        @(negedge clk); @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        chk_reset_outs("post_reset");

        for (int i = 0; i < 6; i++)
            run_op(vecs[i].a, vecs[i].b, vecs[i].cin, vecs[i].exp_sum, vecs[i].exp_cout,
                   0, $sformatf("vec%0d", i));

        // Backpressure: new operands presented during DONE are taken only once IDLE.
        run_op(32'h00010002, 32'h00030004, 1'b0, 32'h00040006, 1'b0, 5, "bp");
        run_op(32'hCAFE0000, 32'h0000BABE, 1'b1, 32'hCAFEBABF, 1'b0, 0, "bp_next");

        // Reset during the 4th RUN cycle.
        in_valid = 1'b1; a = 32'hFFFFFFFF; b = 32'hFFFFFFFF; cin = 1'b1;
        @(negedge clk);
        in_valid = 1'b0;
        @(negedge clk); @(negedge clk); @(negedge clk);
        chk("mid.slice_sel", 64'(slice_sel), 64'd3);
        rst = 1'b1;
        #1;
        chk_reset_outs("mid_reset");
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        chk("mid.idle_valid", 64'(out_valid), 64'd0);
        run_op(32'h0000000F, 32'h00000001, 1'b0, 32'h00000010, 1'b0, 0, "after_rst");

        // Back-to-back with in_valid held high: accepts every 10 cycles.
        begin
            int cyc, n_acc, n_out, acc0, acc1;
            logic [31:0] s[2];
            logic        c[2];
            cyc = 0; n_acc = 0; n_out = 0; acc0 = 0; acc1 = 0;
            s[0] = '0; s[1] = '0; c[0] = 1'b0; c[1] = 1'b0;
            out_ready = 1'b1;
            in_valid = 1'b1; a = 32'h80000000; b = 32'h80000000; cin = 1'b0;
            while (n_out < 2 && cyc < 40) begin
                if (n_acc == 1) begin a = 32'h7FFFFFFF; b = 32'h00000001; end
                if (in_ready) begin
                    if (n_acc == 0) acc0 = cyc; else if (n_acc == 1) acc1 = cyc;
                    n_acc++;
                end
                if (out_valid) begin
                    s[n_out] = sum; c[n_out] = cout; n_out++;
                    if (n_out == 2) in_valid = 1'b0;
                end
                @(negedge clk);
                cyc++;
            end
            chk("b2b.results_seen", 64'(n_out), 64'd2);
            chk("b2b.period", 64'(acc1 - acc0), 64'd10);
            chk("b2b.sum0",  64'(s[0]), 64'h00000000);
            chk("b2b.cout0", 64'(c[0]), 64'd1);
            chk("b2b.sum1",  64'(s[1]), 64'h80000000);
            chk("b2b.cout1", 64'(c[1]), 64'd0);
            @(negedge clk);
        end

        // Random operands against a plain 33-bit addition.
        for (int r = 0; r < 20; r++) begin
            ra = $urandom; rb = $urandom; rc = 1'($urandom_range(0, 1));
            model = {1'b0, ra} + {1'b0, rb} + 33'(rc);
            run_op(ra, rb, rc, model[31:0], model[32], (r % 5 == 0) ? 2 : 0,
                   $sformatf("rnd%0d", r));
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: got running expected finished");
        $fatal(1);
    end
endmodule
